// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID pipeline register with prefetch queue; optional same-cycle bypass under `define IFQ_BYPASS_EN
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               stall,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [AW-1:0]            if_pc,
    input  logic [DW-1:0]            if_inst,
    output logic                     if_ready,
    output logic [AW-1:0]            id_pc,
    output logic [DW-1:0]            id_inst,
    output logic                     id_valid,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [AW+DW-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;

    logic push;
    logic pop;
    logic bypass;
    logic enq;

    // Only stall[1] (IF held) and stall[2] (ID held) matter here.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:3], stall[0]};

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign if_ready = !rst && (count != FULL);
    assign q_count  = count;

    // Decide this cycle's accepted push, pop and (optionally) bypass.
    always_comb begin
        push   = if_valid && if_ready;
        pop    = 1'b0;
        bypass = 1'b0;
        if (!flush && !stall[2] && !stall[1]) begin
            if (count != '0) begin
                pop = 1'b1;
            end
`ifdef IFQ_BYPASS_EN
            else if (push) begin
                bypass = 1'b1;
            end
`endif
        end
        enq = push && !bypass && !flush;
    end

    // Queue storage; a bypassed or flushed push is never written.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= {if_pc, if_inst};
        end
    end

    // Pointers, occupancy and the ID register, in rst > flush > stall priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            id_pc    <= '0;
            id_inst  <= '0;
            id_valid <= 1'b0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            id_pc    <= '0;
            id_inst  <= '0;
            id_valid <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (!stall[2]) begin
                if (stall[1]) begin
                    id_pc    <= '0;
                    id_inst  <= '0;
                    id_valid <= 1'b0;
                end else if (pop) begin
                    {id_pc, id_inst} <= mem[rd_ptr];
                    id_valid         <= 1'b1;
                end else if (bypass) begin
                    id_pc    <= if_pc;
                    id_inst  <= if_inst;
                    id_valid <= 1'b1;
                end else begin
                    id_pc    <= '0;
                    id_inst  <= '0;
                    id_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue (vector table, directed sequences, random vs queue model)
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [5:0]             stall;
    logic                   flush;
    logic                   if_valid;
    logic [AW-1:0]          if_pc;
    logic [DW-1:0]          if_inst;
    logic                   if_ready;
    logic [AW-1:0]          id_pc;
    logic [DW-1:0]          id_inst;
    logic                   id_valid;
    logic [$clog2(DEPTH):0] q_count;

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
        .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .q_count(q_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an unbounded-looking queue capped at DEPTH plus an ID slot.
    logic [63:0] mq[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_inst  = '0;
    logic        m_loaded;
    logic [31:0] seen[$];
    logic        dut_rdy;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bubble();
        m_valid = 1'b0;
        m_pc    = '0;
        m_inst  = '0;
    endtask

    // One clock: drive inputs, check ready, advance the model, check registered outputs.
    task automatic cyc(input bit r, input bit f, input logic [5:0] s, input bit v,
                       input logic [31:0] pc, output bit acc);
        bit ready;
        bit push;
        rst = r; flush = f; stall = s; if_valid = v; if_pc = pc; if_inst = inst_of(pc);
        #1;
        ready   = !r && (mq.size() != DEPTH);
        dut_rdy = if_ready;
        check("if_ready", if_ready, ready);
        push     = v && ready;
        acc      = push;
        m_loaded = 1'b0;
        if (r || f) begin
            mq.delete();
            bubble();
        end else if (s[2]) begin
            if (push) mq.push_back({pc, inst_of(pc)});
        end else if (s[1]) begin
            bubble();
            if (push) mq.push_back({pc, inst_of(pc)});
        end else if (mq.size() > 0) begin
            {m_pc, m_inst} = mq.pop_front();
            m_valid  = 1'b1;
            m_loaded = 1'b1;
            if (push) mq.push_back({pc, inst_of(pc)});
        end else if (push && BYP) begin
            m_pc     = pc;
            m_inst   = inst_of(pc);
            m_valid  = 1'b1;
            m_loaded = 1'b1;
        end else begin
            bubble();
            if (push) mq.push_back({pc, inst_of(pc)});
        end
        @(posedge clk);
        #1;
        check("id_valid", id_valid, m_valid);
        check("id_pc", id_pc, m_pc);
        check("id_inst", id_inst, m_inst);
        check("q_count", q_count, mq.size());
        if (m_loaded) seen.push_back(id_pc);
    endtask

    typedef struct {
        bit          r;
        bit          f;
        logic [5:0]  s;
        bit          v;
        logic [31:0] pc;
        bit          e_rdy;
        bit          e_v;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        bit acc;
        int idx;
        logic [31:0] want[$];

        rst = 1'b1; flush = 1'b0; stall = '0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        @(posedge clk);
        #1;

        // Reset, streaming, ID hold and branch stall as hand-derived vectors.
        tbl[0] = '{1, 0, 6'b000000, 1, 32'h50,  0, 0, 32'h0,   0};
        tbl[1] = '{1, 0, 6'b000000, 1, 32'h50,  0, 0, 32'h0,   0};
`ifdef IFQ_BYPASS_EN
        tbl[2] = '{0, 0, 6'b000000, 1, 32'h100, 1, 1, 32'h100, 0};
        tbl[3] = '{0, 0, 6'b000000, 1, 32'h104, 1, 1, 32'h104, 0};
        tbl[4] = '{0, 0, 6'b000000, 1, 32'h108, 1, 1, 32'h108, 0};
        tbl[5] = '{0, 0, 6'b000000, 0, 32'h0,   1, 0, 32'h0,   0};
        tbl[6] = '{0, 0, 6'b000100, 1, 32'h110, 1, 0, 32'h0,   1};
        tbl[7] = '{0, 0, 6'b000100, 1, 32'h114, 1, 0, 32'h0,   2};
`else
        tbl[2] = '{0, 0, 6'b000000, 1, 32'h100, 1, 0, 32'h0,   1};
        tbl[3] = '{0, 0, 6'b000000, 1, 32'h104, 1, 1, 32'h100, 1};
        tbl[4] = '{0, 0, 6'b000000, 1, 32'h108, 1, 1, 32'h104, 1};
        tbl[5] = '{0, 0, 6'b000000, 0, 32'h0,   1, 1, 32'h108, 0};
        tbl[6] = '{0, 0, 6'b000100, 1, 32'h110, 1, 1, 32'h108, 1};
        tbl[7] = '{0, 0, 6'b000100, 1, 32'h114, 1, 1, 32'h108, 2};
`endif
        tbl[8]  = '{0, 0, 6'b000010, 0, 32'h0, 1, 0, 32'h0,   2};
        tbl[9]  = '{0, 0, 6'b000000, 0, 32'h0, 1, 1, 32'h110, 1};
        tbl[10] = '{0, 0, 6'b111001, 0, 32'h0, 1, 1, 32'h114, 0};
        tbl[11] = '{0, 0, 6'b000000, 0, 32'h0, 1, 0, 32'h0,   0};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].v, tbl[i].pc, acc);
            check($sformatf("tbl%0d_rdy", i), dut_rdy, tbl[i].e_rdy);
            check($sformatf("tbl%0d_valid", i), id_valid, tbl[i].e_v);
            check($sformatf("tbl%0d_pc", i), id_pc, tbl[i].e_pc);
            check($sformatf("tbl%0d_inst", i), id_inst, tbl[i].e_v ? inst_of(tbl[i].e_pc) : 32'h0);
            check($sformatf("tbl%0d_cnt", i), q_count, tbl[i].e_cnt);
        end

        // Load stall: queue fills, ready drops, fetch holds its pair, order preserved.
        seen.delete();
        cyc(0, 0, 6'b000000, 1, 32'h1F0, acc);
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            cyc(0, 0, (c < 5) ? 6'b000111 : 6'b000000, idx < 4, 32'h200 + 4 * idx, acc);
            if (acc) idx++;
            if (c == 4) begin
                check("load_full_cnt", q_count, DEPTH);
                check("load_full_rdy", if_ready, 1'b0);
            end
        end
        check("load_all_accepted", idx, 4);
        want = '{32'h1F0, 32'h200, 32'h204, 32'h208, 32'h20C};
        check("load_order_len", seen.size(), want.size());
        for (int i = 0; i < want.size() && i < seen.size(); i++)
            check($sformatf("load_order%0d", i), seen[i], want[i]);

        // Flush with a full queue, then flush dropping an accepted same-cycle push.
        seen.delete();
        for (int i = 0; i < 4; i++) cyc(0, 0, 6'b000100, 1, 32'h2A0 + 4 * i, acc);
        cyc(0, 1, 6'b000000, 1, 32'h300, acc);
        check("flush_full_valid", id_valid, 1'b0);
        check("flush_full_cnt", q_count, 0);
        cyc(0, 0, 6'b000100, 1, 32'h2C0, acc);
        cyc(0, 1, 6'b000000, 1, 32'h300, acc);
        check("flush_push_accepted", acc, 1'b1);
        check("flush_drop_cnt", q_count, 0);
        cyc(0, 0, 6'b000000, 1, 32'h400, acc);
        cyc(0, 0, 6'b000000, 0, 32'h0, acc);
        cyc(0, 0, 6'b000000, 0, 32'h0, acc);
        check("flush_seen_len", seen.size(), 1);
        if (seen.size() > 0) check("flush_next_pc", seen[0], 32'h400);

        // Wrap-around: 2*DEPTH+1 pairs with alternating ID stall.
        seen.delete();
        want.delete();
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(0, 0, c[0] ? 6'b000100 : 6'b000000, idx < 2 * DEPTH + 1, 32'h500 + 4 * idx, acc);
            if (acc) begin
                want.push_back(32'h500 + 4 * idx);
                idx++;
            end
        end
        check("wrap_len", seen.size(), 2 * DEPTH + 1);
        for (int i = 0; i < want.size() && i < seen.size(); i++)
            check($sformatf("wrap_order%0d", i), seen[i], want[i]);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b000000,
                $urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, acc);
        end

        // Reset mid-operation clears everything and holds ready low.
        cyc(0, 0, 6'b000100, 1, 32'h600, acc);
        cyc(1, 0, 6'b000000, 1, 32'h604, acc);
        check("midrst_valid", id_valid, 1'b0);
        check("midrst_cnt", q_count, 0);
        check("midrst_rdy", if_ready, 1'b0);
        cyc(0, 0, 6'b000000, 0, 32'h0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
